dbx_decoder: RTL and testbench
==============================

Name: dbx_decoder

Overview:
- Inverse of the compressor's bitplane-transpose/XOR stage (DBX); sits in the decompressor datapath.
- Takes a 256-bit bitplane-XOR word and recovers the 32-byte difference vector.
- Rebuilds one bitplane per clock with a running XOR, then un-transposes to bytes.
- Ready/valid handshakes on both sides; one block in flight.

Parameters:
- NUM_BYTES, 32, bytes per block; fixed; other values unsupported.
- NUM_PLANES, 8, bitplanes per block (bits per byte); fixed.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- bpx_i  in  256  plane j at bpx_i[255-32j : 224-32j]; within a plane, column c (byte c) at bit 31-c.
- bpx_valid_i  in  1  input block valid.
- bpx_ready_o  out  1  decoder can accept a block.
- diff_o  out  256  byte r at diff_o[255-8r : 248-8r]; bit k (k=0 is MSB) at diff_o[255-8r-k].
- diff_valid_o  out  1  diff_o holds a complete result.
- diff_ready_i  in  1  downstream accepts the result.

Behaviour:
- Math, with X = input planes and P = recovered planes:
  - P[0] = X[0].
  - For j = 1..7: P[j][0] = X[j][0].
  - For j = 1..7, c = 1..31: P[j][c] = X[j][c] ^ P[j-1][c].
  - Column 0 is never XORed.
- Byte r bit k = P[k][r]; this is the exact inverse of the encoder transpose/XOR.
- FSM states: IDLE, DECODE, DONE.
  - IDLE: bpx_ready_o=1. On bpx_valid_i&bpx_ready_o at edge E0: capture bpx_i into input register, clear plane counter, go to DECODE.
  - DECODE: bpx_ready_o=0. Each edge computes P[cnt] from X[cnt] and the previous-plane register, then writes the plane into its column slice of the byte-array register.
    - cnt increments 0..7. P[0] uses a zero previous plane with root handling identical.
    - Edges E1..E8 process planes 0..7. After E8 go to DONE.
  - DONE: diff_valid_o=1, diff_o stable. On diff_ready_i go to IDLE at that edge.
    - diff_o keeps its value afterwards, but diff_valid_o drops.
- Latency: diff_valid_o rises 8 cycles after the input handshake edge.
- Throughput: one block per 10 cycles minimum (accept, 8 decode cycles, output handshake cycle).
- diff_ready_i is ignored outside DONE. bpx_valid_i is ignored outside IDLE, with no capture.
- Outputs are registered; there is no combinational path from any input to any output.
- Reset, asynchronous at any time including mid-DECODE:
  - state=IDLE, cnt=0, diff_o=0, diff_valid_o=0, bpx_ready_o=1.
  - Internal plane registers are cleared.
  - The partial block is discarded; no output is produced for it.
- diff_valid_o holding while diff_ready_i=0 is indefinite; diff_o must not change while valid.

Decomposition:
- Shared package (compressor/decompressor) holds:
  - localparams NUM_BYTES=32, NUM_PLANES=8, PLANE_W=32, BLOCK_W=256.
  - The FSM state enum encoding.
  - Slice helper constants for plane offsets.
- Sub-module dbx_plane_xor: purely combinational, one plane step. Inputs: X plane (32), previous P plane (32), first-plane flag. Output: P plane (32). Applies the root-column rule.
- Top module holds the FSM, counter, registers and the un-transpose writes.

Test Plan:
- All zeros: bpx_i=0 -> diff_o=0, diff_valid_o exactly 8 cycles after the handshake.
- Single byte: bpx_i={8{32'h80000000}} -> diff_o byte 0 = 0xFF, bytes 1..31 = 0x00.
- All-MSB pattern: bpx_i={32'hFFFFFFFF,32'h7FFFFFFF,{6{32'h0}}} -> every byte 0x80.
- All ones: bpx_i={32'hFFFFFFFF,{7{32'h80000000}}} -> every byte 0xFF.
- Backpressure: hold diff_ready_i=0 for 5 cycles in DONE.
  - diff_o and diff_valid_o must stay stable and bpx_ready_o=0.
  - A new bpx_valid_i must not be captured until the cycle after the output handshake.
- Reset mid-DECODE: assert rst_i at cnt=4.
  - Outputs go to reset values immediately.
  - The next block (random, checked against a golden encoder model) decodes correctly.
- Random sweep (1000 blocks, random valid/ready): encode(diff) through the DBX model, then decode; output must equal diff.

Source files
------------

// File: rtl/dbx_decoder_pkg.sv
// Shared DBX definitions: block geometry, FSM encoding and plane slice helpers.
package dbx_decoder_pkg;

    localparam int NUM_BYTES  = 32;
    localparam int NUM_PLANES = 8;
    localparam int PLANE_W    = 32;
    localparam int BLOCK_W    = 256;
    localparam int CNT_W      = 3;

    localparam logic [CNT_W-1:0] LAST_PLANE = CNT_W'(NUM_PLANES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_DONE   = 2'd2
    } dbx_state_t;

    // Plane j occupies [plane_hi(j) -: PLANE_W]; plane 0 is the top word.
    function automatic int plane_hi(input int j);
        return BLOCK_W - 1 - PLANE_W * j;
    endfunction

    // Byte r occupies [byte_hi(r) -: 8]; byte 0 is the top byte.
    function automatic int byte_hi(input int r);
        return BLOCK_W - 1 - NUM_PLANES * r;
    endfunction

endpackage

// File: rtl/dbx_decoder_if.sv
// Handshake bundle for the DBX decoder: bitplane-XOR input side and difference output side.
interface dbx_decoder_if;
    import dbx_decoder_pkg::*;

    logic [BLOCK_W-1:0] bpx_i;
    logic               bpx_valid_i;
    logic               bpx_ready_o;
    logic [BLOCK_W-1:0] diff_o;
    logic               diff_valid_o;
    logic               diff_ready_i;

    // Decoder side.
    modport slave (
        input  bpx_i,
        input  bpx_valid_i,
        input  diff_ready_i,
        output bpx_ready_o,
        output diff_o,
        output diff_valid_o
    );

    // Upstream/downstream side.
    modport master (
        output bpx_i,
        output bpx_valid_i,
        output diff_ready_i,
        input  bpx_ready_o,
        input  diff_o,
        input  diff_valid_o
    );

endinterface

// File: rtl/dbx_decoder_plane_xor.sv
// One running-XOR plane step: P = X ^ P_prev everywhere except the root column.
module dbx_plane_xor
    import dbx_decoder_pkg::*;
(
    input  logic [PLANE_W-1:0] x_plane,
    input  logic [PLANE_W-1:0] prev_plane,
    input  logic               first,
    output logic [PLANE_W-1:0] p_plane
);

    // Column 0 sits at the MSB and is never XORed; the first plane sees a zero predecessor.
    logic [PLANE_W-1:0] prev_mask;

    assign prev_mask = {1'b0, {(PLANE_W-1){~first}}};
    assign p_plane   = x_plane ^ (prev_plane & prev_mask);

endmodule

// File: rtl/dbx_decoder.sv
// DBX decoder: rebuilds one bitplane per clock from the XOR word and un-transposes
// the planes back into the 32-byte difference vector.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | ready for a block; capture on valid
// ST_DECODE | planes 0..7 rebuilt, one per clock, shifted into the bytes
// ST_DONE   | result held on diff_o until downstream takes it
module dbx_decoder
    import dbx_decoder_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    dbx_decoder_if.slave  bus
);

    dbx_state_t         state;
    dbx_state_t         state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [BLOCK_W-1:0] in_q;
    logic [BLOCK_W-1:0] diff_q;
    logic [PLANE_W-1:0] prev_q;
    logic [PLANE_W-1:0] p_plane;
    logic               first_plane;

    assign first_plane = (cnt == '0);

    // The input register shifts up one plane per step, so the current plane is always the top word.
    dbx_plane_xor u_plane_xor (
        .x_plane    (in_q[plane_hi(0) -: PLANE_W]),
        .prev_plane (prev_q),
        .first      (first_plane),
        .p_plane    (p_plane)
    );

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; both outputs decode only the state register.
    always_comb begin
        state_nxt        = state;
        bus.bpx_ready_o  = 1'b0;
        bus.diff_valid_o = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.bpx_ready_o = 1'b1;
                if (bus.bpx_valid_i) begin
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (cnt == LAST_PLANE) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.diff_valid_o = 1'b1;
                if (bus.diff_ready_i) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Capture, plane counter and un-transpose: each byte shifts left and takes its column bit,
    // so after eight planes plane 0 lands in the byte MSB.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            in_q   <= '0;
            prev_q <= '0;
            diff_q <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.bpx_valid_i) begin
                        in_q   <= bus.bpx_i;
                        prev_q <= '0;
                        cnt    <= '0;
                    end
                end
                ST_DECODE: begin
                    in_q   <= in_q << PLANE_W;
                    prev_q <= p_plane;
                    cnt    <= cnt + 1'b1;
                    for (int b = 0; b < NUM_BYTES; b++) begin
                        diff_q[NUM_PLANES*b +: NUM_PLANES] <=
                            {diff_q[NUM_PLANES*b +: NUM_PLANES-1], p_plane[b]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.diff_o = diff_q;

endmodule

// File: tb/tb_dbx_decoder.sv
// Scoreboard bench for dbx_decoder: driver pushes expected difference vectors at the
// input handshake, a negedge monitor pops and compares at every output handshake.
module tb_dbx_decoder;
    import dbx_decoder_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    dbx_decoder_if bus();

    dbx_decoder dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    logic [255:0] sb[$];
    bit   rand_ready  = 1'b0;
    logic ready_level = 1'b1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Reference DBX encoder: byte r bit k (k=0 MSB) is P[k][r]; X[j][c] = P[j][c]^P[j-1][c] off the root.
    function automatic logic [255:0] encode(input logic [255:0] d);
        logic [255:0] x;
        logic pb, pprev;
        x = '0;
        for (int j = 0; j < 8; j++) begin
            for (int c = 0; c < 32; c++) begin
                pb    = d[255 - 8*c - j];
                pprev = (j == 0) ? 1'b0 : d[255 - 8*c - (j-1)];
                x[255 - 32*j - c] = (c == 0) ? pb : (pb ^ pprev);
            end
        end
        return x;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int w = 0; w < 8; w++) v[32*w +: 32] = $urandom();
        return v;
    endfunction

    // Downstream ready: applied 2 time units after each posedge, either level or random.
    initial begin
        bus.diff_ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #2;
            bus.diff_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
        end
    end

    // Monitor: compare at handshakes, and check hold stability whenever the last cycle stalled.
    initial begin
        logic hold;
        logic [255:0] prev;
        hold = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("hold_valid", 256'(bus.diff_valid_o), 256'(1));
                    check("hold_data", bus.diff_o, prev);
                end
                if (bus.diff_valid_o && bus.diff_ready_i) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_output: got %h required none", bus.diff_o);
                    end else begin
                        check("result", bus.diff_o, sb.pop_front());
                    end
                end
                hold = bus.diff_valid_o && !bus.diff_ready_i;
                prev = bus.diff_o;
            end
        end
    end

    // Present a block from a posedge+1 slot and push its expectation at the accepting edge.
    task automatic send_block(input logic [255:0] x, input logic [255:0] exp);
        int n;
        @(posedge clk_i);
        #1;
        bus.bpx_i       = x;
        bus.bpx_valid_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!bus.bpx_ready_o && n < 200);
        if (!bus.bpx_ready_o) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got ready=0 required ready=1");
            bus.bpx_valid_i = 1'b0;
        end else begin
            @(posedge clk_i);
            sb.push_back(exp);
            #1;
            bus.bpx_valid_i = 1'b0;
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!bus.diff_valid_o && n < 300);
        if (!bus.diff_valid_o) begin
            total++;
            bad++;
            $display("FAIL valid_timeout: got valid=0 required valid=1");
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk_i);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got pending=%0d required pending=0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        logic [255:0] d;
        logic [255:0] snap;
        logic [255:0] blk_b;
        logic [255:0] exp_b;
        int n;

        bus.bpx_i       = '0;
        bus.bpx_valid_i = 1'b0;

        repeat (3) @(posedge clk_i);
        #1;
        check("reset_ready", 256'(bus.bpx_ready_o), 256'(1));
        check("reset_valid", 256'(bus.diff_valid_o), 256'(0));
        check("reset_diff", bus.diff_o, '0);
        rst_i = 1'b0;

        // All zeros, with latency from the accepting edge to diff_valid_o.
        send_block('0, '0);
        wait_valid(n);
        check("latency", 256'(n - 1), 256'(8));
        drain();

        // Directed hand-computed patterns back to back.
        send_block({8{32'h8000_0000}}, {8'hFF, 248'h0});
        send_block({32'hFFFF_FFFF, 32'h7FFF_FFFF, 192'h0}, {32{8'h80}});
        send_block({32'hFFFF_FFFF, {7{32'h8000_0000}}}, {256{1'b1}});
        drain();

        // Backpressure: hold ready low for 5 cycles in DONE with a new block waiting.
        @(posedge clk_i);
        #1;
        ready_level = 1'b0;
        d = rand256();
        send_block(encode(d), d);
        wait_valid(n);
        snap  = bus.diff_o;
        exp_b = rand256();
        blk_b = encode(exp_b);
        @(posedge clk_i);
        #1;
        bus.bpx_i       = blk_b;
        bus.bpx_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("bp_valid", 256'(bus.diff_valid_o), 256'(1));
            check("bp_data", bus.diff_o, snap);
            check("bp_no_accept", 256'(bus.bpx_ready_o), 256'(0));
        end
        @(posedge clk_i);
        #1;
        ready_level = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        check("bp_idle_ready", 256'(bus.bpx_ready_o), 256'(1));
        check("bp_valid_drop", 256'(bus.diff_valid_o), 256'(0));
        check("bp_data_kept", bus.diff_o, snap);
        @(posedge clk_i);
        sb.push_back(exp_b);
        #1;
        bus.bpx_valid_i = 1'b0;
        drain();

        // Reset at cnt=4 discards the partial block.
        d = rand256();
        send_block(encode(d), d);
        repeat (4) @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        sb.delete();
        #1;
        check("midrst_diff", bus.diff_o, '0);
        check("midrst_valid", 256'(bus.diff_valid_o), 256'(0));
        check("midrst_ready", 256'(bus.bpx_ready_o), 256'(1));
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        repeat (12) @(negedge clk_i);
        check("midrst_no_output", 256'(bus.diff_valid_o), 256'(0));
        d = rand256();
        send_block(encode(d), d);
        drain();

        // Random sweep with random gaps and random downstream ready.
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk_i);
            d = rand256();
            send_block(encode(d), d);
        end
        rand_ready = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
